// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller,
// plus a behavioural reference sum used by verification.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int DEFAULT_W = 8;

    // Returns {cout, sum} of a + b + cin truncated to w+1 bits (w in 2..32).
    function automatic logic [32:0] add_ref(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        cin,
        input int          w
    );
        logic [32:0] full;
        logic [32:0] mask;
        full = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        mask = (33'd1 << (w + 1)) - 33'd1;
        return full & mask;
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder with a registered carry; the carry can be loaded
// with an external carry-in or cleared ahead of a new serial pass.
module serial_fa_cell (
    input  logic clk,
    input  logic nrst,
    input  logic load,
    input  logic clr,
    input  logic en,
    input  logic cin,
    input  logic a,
    input  logic b,
    output logic s,
    output logic co
);

    logic c_reg;
    logic c_next;

    assign s  = a ^ b ^ c_reg;
    assign co = (a & b) | (a & c_reg) | (b & c_reg);

    always_comb begin
        c_next = c_reg;
        if (clr) begin
            c_next = 1'b0;
        end else if (load) begin
            c_next = cin;
        end else if (en) begin
            c_next = co;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            c_reg <= 1'b0;
        end else begin
            c_reg <= c_next;
        end
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencer for a bit-serial adder: captures operands, streams them LSB-first
// through serial_fa_cell and rebuilds the parallel sum with a done pulse.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         CLK,
    input  logic         NRST,
    input  logic         start,
    input  logic         clr,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         cin,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int CW = $clog2(W);

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [W-1:0]  a_reg, a_next;
    logic [W-1:0]  b_reg, b_next;
    logic [W-1:0]  sum_reg, sum_next;
    logic          cout_reg, cout_next;
    logic [W-1:0]  a_shift, b_shift;
    logic          accept;
    logic          shifting;
    logic          last_bit;
    logic          fa_s;
    logic          fa_co;

    assign ready    = (state_reg == IDLE) || (state_reg == DONE);
    assign busy     = (state_reg == SHIFT);
    assign done     = (state_reg == DONE);
    assign sum      = sum_reg;
    assign cout     = cout_reg;

    assign accept   = start && ready && !clr;
    assign shifting = busy && !clr;
    assign last_bit = (cnt_reg == CW'(W - 1));

    // Operand registers shift right, filling the vacated MSB with zero.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_shift
            if (gi == W - 1) begin : g_top
                assign a_shift[gi] = 1'b0;
                assign b_shift[gi] = 1'b0;
            end else begin : g_mid
                assign a_shift[gi] = a_reg[gi+1];
                assign b_shift[gi] = b_reg[gi+1];
            end
        end
    endgenerate

    serial_fa_cell u_fa (
        .clk  (CLK),
        .nrst (NRST),
        .load (accept),
        .clr  (clr),
        .en   (shifting),
        .cin  (cin),
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .s    (fa_s),
        .co   (fa_co)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        sum_next   = sum_reg;
        cout_next  = cout_reg;
        if (clr) begin
            state_next = IDLE;
            cnt_next   = '0;
            a_next     = '0;
            b_next     = '0;
            sum_next   = '0;
            cout_next  = 1'b0;
        end else begin
            unique case (state_reg)
                IDLE, DONE: begin
                    if (accept) begin
                        state_next = SHIFT;
                        cnt_next   = '0;
                        a_next     = a_in;
                        b_next     = b_in;
                        sum_next   = '0;
                        cout_next  = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end
                SHIFT: begin
                    // Sum bits enter at the MSB so bit0 lands in sum[0] after W shifts.
                    sum_next = {fa_s, sum_reg[W-1:1]};
                    a_next   = a_shift;
                    b_next   = b_shift;
                    cnt_next = cnt_reg + CW'(1);
                    if (last_bit) begin
                        cout_next  = fa_co;
                        state_next = DONE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            sum_reg   <= sum_next;
            cout_reg  <= cout_next;
        end
    end

endmodule
